// File: rtl/scarv_cop_issue_ctrl_pkg.sv
// Shared constants for the coprocessor issue path: class indices, response
// status codes and the issue FSM state encoding.
package scarv_cop_issue_ctrl_pkg;

    localparam int SCARV_COP_NCLASS            = 9;
    localparam int SCARV_COP_ICLASS_PACKED_ARITH = 0;
    localparam int SCARV_COP_ICLASS_TWIDDLE    = 1;
    localparam int SCARV_COP_ICLASS_MP         = 2;
    localparam int SCARV_COP_ICLASS_BITWISE    = 3;
    localparam int SCARV_COP_ICLASS_LOADSTORE  = 4;
    localparam int SCARV_COP_ICLASS_RANDOM     = 5;
    localparam int SCARV_COP_ICLASS_MOVE       = 6;
    localparam int SCARV_COP_ICLASS_AES        = 7;
    localparam int SCARV_COP_ICLASS_SHA3       = 8;

    localparam logic [2:0] SCARV_COP_INSN_SUCCESS  = 3'd0;
    localparam logic [2:0] SCARV_COP_INSN_ABORT    = 3'd1;
    localparam logic [2:0] SCARV_COP_INSN_BAD_INS  = 3'd2;
    localparam logic [2:0] SCARV_COP_INSN_BAD_FEAT = 3'd3;

    typedef enum logic [2:0] {
        ST_INIT   = 3'd0,
        ST_IDLE   = 3'd1,
        ST_DECODE = 3'd2,
        ST_EXEC   = 3'd3,
        ST_RESP   = 3'd4
    } state_e;

    // Counter width able to hold 0..n-1, never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/scarv_cop_onehot_chk.sv
// Combinational zero-hot / multi-hot detector; a vector that is neither is
// exactly one-hot.
module scarv_cop_onehot_chk #(
    parameter int W = 9
) (
    input  logic [W-1:0] vec,
    output logic         is_zero,
    output logic         is_multi
);

    // Clearing the lowest set bit leaves something only if two or more were set.
    assign is_zero  = (vec == '0);
    assign is_multi = |(vec & (vec - W'(1)));

endmodule

// File: rtl/scarv_cop_issue_ctrl.sv
// Issue controller: accepts one ISE instruction at a time, checks the decoded
// class, dispatches it to a functional unit and returns a status response.
//
// state  | meaning
// INIT   | zeroing CPRs 0..NCPR-1, one per cycle
// IDLE   | waiting for cpu_insn_req
// DECODE | legality check of decoder outputs
// EXEC   | functional unit requested, waiting for done or timeout
// RESP   | response presented until cpu_rsp_ack
module scarv_cop_issue_ctrl
    import scarv_cop_issue_ctrl_pkg::*;
#(
    parameter logic [8:0]  ISE_MCCR_MASK = 9'h1FF,
    parameter int unsigned TIMEOUT       = 64,
    parameter int unsigned NCPR          = 16
) (
    input  logic        g_clk,
    input  logic        g_resetn,
    input  logic        cpu_insn_req,
    output logic        cpu_insn_ack,
    input  logic [31:0] cpu_insn_enc,
    output logic [31:0] dec_encoded,
    input  logic [8:0]  dec_class,
    input  logic        dec_exception,
    output logic [8:0]  fu_req,
    input  logic [8:0]  fu_done,
    output logic        cprs_clr_en,
    output logic [3:0]  cprs_clr_addr,
    output logic        cpu_rsp_req,
    input  logic        cpu_rsp_ack,
    output logic [2:0]  cpu_rsp_status,
    output logic        busy
);

    localparam int unsigned TW = cnt_width(TIMEOUT);

    state_e      state_q, state_d;
    logic [3:0]  clr_cnt_q, clr_cnt_d;
    logic [31:0] enc_q, enc_d;
    logic [8:0]  class_q, class_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic [2:0]  status_q, status_d;

    logic        clr_en;
    logic        cls_zero, cls_multi;
    logic        unit_done, tmo_hit;

    scarv_cop_onehot_chk #(.W(9)) u_onehot_chk (
        .vec      (dec_class),
        .is_zero  (cls_zero),
        .is_multi (cls_multi)
    );

    assign unit_done = |(fu_done & class_q);
    assign tmo_hit   = (TIMEOUT != 0) && (tmo_q == TW'(TIMEOUT - 1));

    always_comb begin
        state_d      = state_q;
        clr_cnt_d    = clr_cnt_q;
        enc_d        = enc_q;
        class_d      = class_q;
        tmo_d        = tmo_q;
        status_d     = status_q;
        clr_en       = 1'b0;
        cpu_insn_ack = 1'b0;
        cpu_rsp_req  = 1'b0;
        fu_req       = '0;
        case (state_q)
            ST_INIT: begin
                clr_en    = 1'b1;
                clr_cnt_d = clr_cnt_q + 4'd1;
                if (clr_cnt_q == 4'(NCPR - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = ST_IDLE;
                end
            end
            ST_IDLE: begin
                if (cpu_insn_req) begin
                    cpu_insn_ack = 1'b1;
                    enc_d        = cpu_insn_enc;
                    state_d      = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_exception || cls_zero || cls_multi) begin
                    status_d = SCARV_COP_INSN_BAD_INS;
                    state_d  = ST_RESP;
                end else if ((dec_class & ~ISE_MCCR_MASK) != '0) begin
                    status_d = SCARV_COP_INSN_BAD_FEAT;
                    state_d  = ST_RESP;
                end else begin
                    class_d = dec_class;
                    tmo_d   = '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                fu_req = class_q;
                // Completion is checked first so a done on the last allowed
                // cycle still reports success.
                if (unit_done) begin
                    status_d = SCARV_COP_INSN_SUCCESS;
                    state_d  = ST_RESP;
                end else if (tmo_hit) begin
                    status_d = SCARV_COP_INSN_ABORT;
                    state_d  = ST_RESP;
                end else begin
                    tmo_d = tmo_q + TW'(1);
                end
            end
            ST_RESP: begin
                cpu_rsp_req = 1'b1;
                if (cpu_rsp_ack) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    always_ff @(posedge g_clk or negedge g_resetn) begin
        if (!g_resetn) begin
            state_q   <= ST_INIT;
            clr_cnt_q <= '0;
            enc_q     <= '0;
            class_q   <= '0;
            tmo_q     <= '0;
            status_q  <= '0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            enc_q     <= enc_d;
            class_q   <= class_d;
            tmo_q     <= tmo_d;
            status_q  <= status_d;
        end
    end

    // The FSM sits in INIT while reset is held; gating keeps these low then.
    assign cprs_clr_en    = clr_en & g_resetn;
    assign busy           = (state_q != ST_IDLE) & g_resetn;
    assign cprs_clr_addr  = clr_cnt_q;
    assign dec_encoded    = enc_q;
    assign cpu_rsp_status = status_q;

endmodule

// File: tb/tb_scarv_cop_issue_ctrl.sv
// Randomised and directed bench for scarv_cop_issue_ctrl with a rule-level
// reference model of the expected status and execution length.
module tb_scarv_cop_issue_ctrl;
    import scarv_cop_issue_ctrl_pkg::*;

    localparam logic [8:0] MASK = 9'h1FF & ~(9'd1 << SCARV_COP_ICLASS_AES);
    localparam int TMO  = 8;
    localparam int NCPR = 16;

    logic        g_clk = 1'b0;
    logic        g_resetn = 1'b0;
    logic        cpu_insn_req = 1'b0;
    logic        cpu_insn_ack;
    logic [31:0] cpu_insn_enc = '0;
    logic [31:0] dec_encoded;
    logic [8:0]  dec_class;
    logic        dec_exception;
    logic [8:0]  fu_req;
    logic [8:0]  fu_done = '0;
    logic        cprs_clr_en;
    logic [3:0]  cprs_clr_addr;
    logic        cpu_rsp_req;
    logic        cpu_rsp_ack = 1'b0;
    logic [2:0]  cpu_rsp_status;
    logic        busy;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 g_clk = ~g_clk;

    // Stand-in decoder: bit 31 flags an illegal encoding, bits 8:0 carry the class.
    assign dec_exception = dec_encoded[31];
    assign dec_class     = dec_encoded[8:0];

    scarv_cop_issue_ctrl #(
        .ISE_MCCR_MASK (MASK),
        .TIMEOUT       (TMO),
        .NCPR          (NCPR)
    ) dut (
        .g_clk          (g_clk),
        .g_resetn       (g_resetn),
        .cpu_insn_req   (cpu_insn_req),
        .cpu_insn_ack   (cpu_insn_ack),
        .cpu_insn_enc   (cpu_insn_enc),
        .dec_encoded    (dec_encoded),
        .dec_class      (dec_class),
        .dec_exception  (dec_exception),
        .fu_req         (fu_req),
        .fu_done        (fu_done),
        .cprs_clr_en    (cprs_clr_en),
        .cprs_clr_addr  (cprs_clr_addr),
        .cpu_rsp_req    (cpu_rsp_req),
        .cpu_rsp_ack    (cpu_rsp_ack),
        .cpu_rsp_status (cpu_rsp_status),
        .busy           (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    // Reference rules: illegal encoding or not exactly one class -> 2,
    // disabled feature -> 3, done within TMO exec cycles -> 0, else 1.
    function automatic int exp_status(input bit exc, input logic [8:0] cls, input int done_at);
        if (exc || $countones(cls) != 1) return 2;
        if ((cls & ~MASK) != 0) return 3;
        if (done_at >= 0 && done_at < TMO) return 0;
        return 1;
    endfunction

    function automatic int exp_cycles(input int st, input int done_at);
        if (st == 0) return done_at + 1;
        if (st == 1) return TMO;
        return 0;
    endfunction

    function automatic logic [31:0] mk_enc(input bit exc, input logic [8:0] cls);
        logic [31:0] r;
        r = $urandom;
        r[31] = exc;
        r[8:0] = cls;
        return r;
    endfunction

    task automatic check_init();
        int n = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge g_clk);
            if (!cprs_clr_en) break;
            chk("init_addr", cprs_clr_addr, n);
            chk("init_no_ack", cpu_insn_ack, 0);
            chk("init_no_rsp", cpu_rsp_req, 0);
            n++;
        end
        chk("init_len", n, NCPR);
        chk("busy_after_init", busy, 0);
    endtask

    // Entered just after the accepting clock edge.
    task automatic complete_insn(input logic [31:0] enc, input int done_at, input int rsp_delay);
        logic [8:0] cls;
        int st;
        int n_exec;
        bit got;
        cls = enc[8:0];
        st = exp_status(enc[31], cls, done_at);
        n_exec = 0;
        got = 0;
        cpu_insn_enc = $urandom;
        chk("busy_in_flight", busy, 1);
        for (int c = 0; c < 40; c++) begin
            @(negedge g_clk);
            if (cpu_rsp_req) begin
                got = 1;
                break;
            end
            chk("dec_encoded", dec_encoded, enc);
            fu_done = 9'($urandom) & ~cls;
            if (fu_req != 0) begin
                chk("fu_req", fu_req, cls);
                if (n_exec == done_at) fu_done = fu_done | cls;
                n_exec++;
            end
        end
        fu_done = '0;
        chk("rsp_seen", got, 1);
        chk("exec_cycles", n_exec, exp_cycles(st, done_at));
        chk("status", cpu_rsp_status, st);
        for (int d = 0; d < rsp_delay; d++) begin
            @(posedge g_clk);
            @(negedge g_clk);
            chk("rsp_held", cpu_rsp_req, 1);
            chk("status_stable", cpu_rsp_status, st);
        end
        cpu_rsp_ack = 1'b1;
        cpu_insn_req = 1'b1;
        #1;
        chk("no_accept_in_resp", cpu_insn_ack, 0);
        @(posedge g_clk);
        #1;
        cpu_rsp_ack = 1'b0;
        cpu_insn_req = 1'b0;
        @(negedge g_clk);
        chk("rsp_dropped", cpu_rsp_req, 0);
        chk("busy_idle", busy, 0);
    endtask

    task automatic run_insn(input logic [31:0] enc, input int done_at, input int rsp_delay);
        @(negedge g_clk);
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        #1;
        chk("insn_ack", cpu_insn_ack, 1);
        @(posedge g_clk);
        #1;
        cpu_insn_req = 1'b0;
        complete_insn(enc, done_at, rsp_delay);
    endtask

    initial begin
        logic [31:0] enc;
        logic [8:0]  cls;
        int          mode;
        int          done_at;

        // Reset values, with a MOVE instruction already pending.
        enc = mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_MOVE);
        cpu_insn_req = 1'b1;
        cpu_insn_enc = enc;
        @(negedge g_clk);
        @(negedge g_clk);
        chk("rst_clr_en", cprs_clr_en, 0);
        chk("rst_clr_addr", cprs_clr_addr, 0);
        chk("rst_ack", cpu_insn_ack, 0);
        chk("rst_rsp_req", cpu_rsp_req, 0);
        chk("rst_status", cpu_rsp_status, 0);
        chk("rst_fu_req", fu_req, 0);
        chk("rst_busy", busy, 0);
        chk("rst_dec_encoded", dec_encoded, 0);
        @(posedge g_clk);
        #2 g_resetn = 1'b1;
        check_init();
        chk("ack_after_init", cpu_insn_ack, 1);
        @(posedge g_clk);
        #1;
        cpu_insn_req = 1'b0;
        complete_insn(enc, 2, 5);

        // Directed corner cases.
        run_insn(mk_enc(1'b1, 9'd1 << SCARV_COP_ICLASS_MOVE), 0, 0);
        run_insn(mk_enc(1'b0, 9'h003), 0, 1);
        run_insn(mk_enc(1'b0, 9'h000), 0, 0);
        run_insn(mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_AES), 0, 2);
        run_insn(mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_MP), -1, 0);
        run_insn(mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_MP), TMO - 1, 0);
        run_insn(mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_SHA3), 0, 0);

        // Reset in the middle of EXEC drops the instruction and reruns zeroing.
        @(negedge g_clk);
        cpu_insn_req = 1'b1;
        cpu_insn_enc = mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_MOVE);
        @(posedge g_clk);
        #1;
        cpu_insn_req = 1'b0;
        @(negedge g_clk);
        @(negedge g_clk);
        @(negedge g_clk);
        chk("exec_before_rst", fu_req, 9'd1 << SCARV_COP_ICLASS_MOVE);
        #1 g_resetn = 1'b0;
        #1;
        chk("mid_rst_fu_req", fu_req, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_rsp_req", cpu_rsp_req, 0);
        chk("mid_rst_clr_en", cprs_clr_en, 0);
        chk("mid_rst_status", cpu_rsp_status, 0);
        @(posedge g_clk);
        #2 g_resetn = 1'b1;
        check_init();
        run_insn(mk_enc(1'b0, 9'd1 << SCARV_COP_ICLASS_MOVE), 1, 0);

        // Random instructions against the reference rules.
        for (int i = 0; i < 40; i++) begin
            mode = $urandom_range(0, 9);
            if (mode == 0) cls = 9'h000;
            else if (mode == 1) cls = 9'($urandom) | 9'h005;
            else cls = 9'd1 << $urandom_range(0, SCARV_COP_NCLASS - 1);
            done_at = $urandom_range(0, TMO + 1);
            if (done_at >= TMO) done_at = -1;
            run_insn(mk_enc(($urandom_range(0, 7) == 0), cls), done_at, $urandom_range(0, 4));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d/%0d checks passed", n_pass, n_checks);
        $fatal(1, "time limit");
    end

endmodule
